// File: rtl/uart_tx_fifo_if.sv
// Byte-queue and serial-line signals of the FIFO-buffered UART transmitter.
// The master drives writes and frame options; the slave is the transmitter itself.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BW       = 8,
  parameter int unsigned FIFO_ADDR_BIT = 3
);
  logic                   transmit;
  logic [DATA_BW-1:0]     data_in;
  logic [1:0]             parity_mode;
  logic                   two_stop;
  logic                   tx;
  logic                   busy;
  logic                   full;
  logic                   empty;
  logic [FIFO_ADDR_BIT:0] fifo_count;
  logic                   overflow;

  modport master (
    output transmit, data_in, parity_mode, two_stop,
    input  tx, busy, full, empty, fifo_count, overflow
  );

  modport slave (
    input  transmit, data_in, parity_mode, two_stop,
    output tx, busy, full, empty, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO: LSB-first frames with configurable data width,
// optional even/odd parity and one or two stop bits.
module uart_tx_fifo #(
  parameter int unsigned DATA_BW       = 8,
  parameter int unsigned BAUD_COUNT    = 10416,
  parameter int unsigned BAUD_BIT      = 14,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned FIFO_ADDR_BIT = 3
) (
  input logic          clk,
  input logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  localparam logic [BAUD_BIT-1:0]    BaudLast  = BAUD_BIT'(BAUD_COUNT - 1);
  localparam logic [3:0]             BitLast   = 4'(DATA_BW - 1);
  localparam logic [FIFO_ADDR_BIT:0] CountFull = (FIFO_ADDR_BIT + 1)'(FIFO_DEPTH);

  logic [DATA_BW-1:0]       mem_q [FIFO_DEPTH];
  logic [FIFO_ADDR_BIT-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_ADDR_BIT:0]   count_q, count_d;
  logic [2:0]               state_q, state_d;
  logic [BAUD_BIT-1:0]      baud_q, baud_d;
  logic [3:0]               bit_q, bit_d;
  logic [DATA_BW-1:0]       shift_q, shift_d;
  logic                     par_bit_q, par_bit_d;
  logic                     par_en_q, par_en_d;
  logic                     two_stop_q, two_stop_d;
  logic                     stop2_q, stop2_d;
  logic                     tx_q, tx_d;
  logic                     busy_q, busy_d;

  logic full, empty, bit_end, pop, push;

  assign full    = (count_q == CountFull);
  assign empty   = (count_q == '0);
  assign bit_end = (baud_q == BaudLast);
  // A full FIFO still accepts a write on the edge that pops it.
  assign push    = bus.transmit & (~full | pop);

  always_comb begin
    state_d    = state_q;
    baud_d     = (state_q == StIdle || bit_end) ? '0 : baud_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    stop2_d    = stop2_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    pop        = 1'b0;

    case (state_q)
      StIdle: begin
        if (!empty) pop = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          tx_d    = shift_q[0];
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == BitLast) begin
            if (par_en_q) begin
              state_d = StParity;
              tx_d    = par_bit_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
              stop2_d = 1'b0;
            end
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
          stop2_d = 1'b0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame start: options are latched here so mid-frame changes wait for the next frame.
    if (pop) begin
      state_d    = StStart;
      shift_d    = mem_q[rptr_q];
      par_bit_d  = (^mem_q[rptr_q]) ^ (bus.parity_mode == 2'd2);
      par_en_d   = (bus.parity_mode == 2'd1) || (bus.parity_mode == 2'd2);
      two_stop_d = bus.two_stop;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
      baud_d     = '0;
    end

    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wptr_q] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = rst & bus.transmit & full & ~pop;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the team's fixed-format UART transmitter. It takes bytes through the existing one-cycle `transmit` strobe and queues them in an internal FIFO. It serialises each byte LSB-first with a configurable data width, optional even/odd parity and one or two stop bits. It sits between the system logic and the `tx` pad, and drops into top_DUT in place of the current transmitter.

Parameters:
DATA_BW, 8, data bits per frame (5..9)
BAUD_COUNT, 10416, clocks per bit (9600 bps at 100 MHz)
BAUD_BIT, 14, width of the baud counter (must hold BAUD_COUNT-1)
FIFO_DEPTH, 8, FIFO entries (power of two)
FIFO_ADDR_BIT, 3, log2(FIFO_DEPTH)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, synchronous, active-low (rst=0 resets on the next clk edge)
transmit  input  1  write strobe; one cycle high pushes data_in
data_in  input  DATA_BW  byte to queue
parity_mode  input  2  0=none, 1=even, 2=odd, 3=none; sampled at frame start
two_stop  input  1  1 selects two stop bits; sampled at frame start
tx  output  1  serial line, idles high
busy  output  1  high while a frame is on the line
full  output  1  FIFO full
empty  output  1  FIFO empty
fifo_count  output  FIFO_ADDR_BIT+1  current FIFO occupancy
overflow  output  1  one-cycle pulse when a write is dropped

Behaviour:
- Reset values: tx=1, busy=0, full=0, empty=1, fifo_count=0, overflow=0. FSM goes to IDLE, FIFO pointers clear, baud counter=0.
- Reset mid-frame aborts the frame: tx=1 from the reset edge, and queued data is discarded.
- FIFO write: on an edge with transmit=1.
  - Not full: data_in is stored and fifo_count increments.
  - Full with no pop that cycle: the write is dropped and overflow=1 for exactly that cycle.
  - Full with a pop that same edge: the write is accepted.
- FIFO pop: only the FSM pops, on entry to START. A simultaneous push and pop leaves fifo_count unchanged.
- Pointers wrap modulo FIFO_DEPTH. full = (count==FIFO_DEPTH); empty = (count==0).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when !empty.
  - At that edge: pop the head into the shift register, latch parity_mode and two_stop, set tx=0, busy=1, counter=0.
  - Latency: a write accepted at edge k into an empty FIFO in IDLE gives tx=0 after edge k+1.
- Bit timing: each bit lasts exactly BAUD_COUNT clocks. The counter runs 0..BAUD_COUNT-1; the bit advances on the edge where counter==BAUD_COUNT-1.
- START -> DATA.
- DATA: shifts DATA_BW bits LSB-first. After the last bit it goes to PARITY if the latched mode is 1 or 2, otherwise to STOP.
- PARITY bit value:
  - even mode: XOR of the data bits;
  - odd mode: inverted XOR of the data bits.
- STOP: tx=1 for one bit time, or two if two_stop was latched. At the end of the stop bit(s):
  - !empty: go directly to START (pop, tx=0) with no idle gap, busy stays 1;
  - empty: go to IDLE with busy=0.
- Frame length in bit times = 1 + DATA_BW + (parity?1:0) + (two_stop?2:1).
- Changing parity_mode or two_stop mid-frame has no effect until the next frame start.
- The queue holds FIFO_DEPTH entries plus one in the shift register, so FIFO_DEPTH+1 writes can be outstanding.

Test Plan:
- Defaults, parity=0, two_stop=0, send 0xC1 -> tx = 0,1,0,0,0,0,0,1,1,1, each bit held 10416 clocks; busy high for exactly 104160 cycles; tx=0 one edge after the write.
- parity=1, send 0xBE (six ones) -> parity bit 0. parity=2, send 0xEF (seven ones) -> parity bit 0. parity=1, send 0xEF -> parity bit 1. Each frame is 11 bit times.
- BAUD_COUNT=16, 10 writes on consecutive cycles starting in IDLE -> writes 1..9 accepted; write 10 dropped with overflow=1 for one cycle; fifo_count=8 and full=1 afterwards; all nine bytes leave in order, back-to-back.
- Queue 0xC1, 0xBE, 0xEF with two_stop=1 -> every frame is 11 bit times; the next start bit follows the second stop bit with zero idle cycles; busy stays high throughout, then drops; empty=1 at the end.
- Full FIFO with a push on the same edge as a pop -> push accepted, no overflow pulse, fifo_count stays 8.
- rst=0 for one cycle during DATA of a queued burst -> tx=1, busy=0, fifo_count=0 and empty=1 after the edge; a later send of 0x55 transmits correctly.
